i2q2_engine: RTL and testbench

Computes the per-subchannel power metric I²+Q² for the early, prompt and late correlator arms at the end of every accumulation period. It uses a single shared squarer, time-multiplexed over six operands. The block sits between the channel's E/P/L accumulators and the acquisition/tracking controllers. It latches the signed accumulations on `accumulation_complete` and presents held `i2q2_early/prompt/late` results with a one-cycle `i2q2_valid` strobe.

---
 rtl/i2q2_engine.sv | 136 +++++++++++++
 tb/tb_i2q2_engine.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/i2q2_engine.sv
// Per-arm I^2+Q^2 power metric for early/prompt/late correlator arms.
// One shared squarer is time-multiplexed over the six latched operands.
module i2q2_engine #(
  parameter int unsigned ACC_WIDTH  = 16,
  parameter int unsigned I2Q2_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  global_reset,
  input  logic                  accumulation_complete,
  input  logic [ACC_WIDTH-1:0]  i_early,
  input  logic [ACC_WIDTH-1:0]  q_early,
  input  logic [ACC_WIDTH-1:0]  i_prompt,
  input  logic [ACC_WIDTH-1:0]  q_prompt,
  input  logic [ACC_WIDTH-1:0]  i_late,
  input  logic [ACC_WIDTH-1:0]  q_late,
  output logic                  i2q2_valid,
  output logic [I2Q2_WIDTH-1:0] i2q2_early,
  output logic [I2Q2_WIDTH-1:0] i2q2_prompt,
  output logic [I2Q2_WIDTH-1:0] i2q2_late,
  output logic                  busy,
  output logic                  overrun
);

  localparam int unsigned PW = 2 * ACC_WIDTH;

  typedef enum logic [0:0] {StIdle, StSquare} state_e;

  state_e                state_q, state_d;
  logic [2:0]            idx_q, idx_d;
  logic [ACC_WIDTH-1:0]  op_q [6];
  logic [ACC_WIDTH-1:0]  op_d [6];
  logic [I2Q2_WIDTH-1:0] early_q, early_d, prompt_q, prompt_d, late_q, late_d;
  logic [I2Q2_WIDTH-1:0] out_e_q, out_e_d, out_p_q, out_p_d, out_l_q, out_l_d;
  logic                  valid_q, valid_d, overrun_q, overrun_d;

  logic [ACC_WIDTH-1:0]  op_sel;
  logic [PW-1:0]         op_ext, prod;
  logic [I2Q2_WIDTH-1:0] sq;

  always_comb begin
    case (idx_q)
      3'd0:    op_sel = op_q[0];
      3'd1:    op_sel = op_q[1];
      3'd2:    op_sel = op_q[2];
      3'd3:    op_sel = op_q[3];
      3'd4:    op_sel = op_q[4];
      default: op_sel = op_q[5];
    endcase
  end

  // Sign-extend to full width; low PW bits of the product are the exact square.
  assign op_ext = {{ACC_WIDTH{op_sel[ACC_WIDTH-1]}}, op_sel};
  assign prod   = op_ext * op_ext;
  assign sq     = I2Q2_WIDTH'(prod);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    op_d      = op_q;
    early_d   = early_q;
    prompt_d  = prompt_q;
    late_d    = late_q;
    out_e_d   = out_e_q;
    out_p_d   = out_p_q;
    out_l_d   = out_l_q;
    valid_d   = 1'b0;
    overrun_d = overrun_q;

    if (accumulation_complete) begin
      // A strobe while squaring aborts the running computation.
      if (state_q == StSquare) overrun_d = 1'b1;
      op_d[0]  = i_early;
      op_d[1]  = q_early;
      op_d[2]  = i_prompt;
      op_d[3]  = q_prompt;
      op_d[4]  = i_late;
      op_d[5]  = q_late;
      early_d  = '0;
      prompt_d = '0;
      late_d   = '0;
      idx_d    = 3'd0;
      state_d  = StSquare;
    end else if (state_q == StSquare) begin
      idx_d = idx_q + 3'd1;
      case (idx_q)
        3'd0, 3'd1: early_d  = early_q + sq;
        3'd2, 3'd3: prompt_d = prompt_q + sq;
        3'd4:       late_d   = late_q + sq;
        default: begin
          out_e_d = early_q;
          out_p_d = prompt_q;
          out_l_d = late_q + sq;
          valid_d = 1'b1;
          idx_d   = 3'd0;
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (global_reset) begin
      state_q   <= StIdle;
      idx_q     <= 3'd0;
      op_q      <= '{default: '0};
      early_q   <= '0;
      prompt_q  <= '0;
      late_q    <= '0;
      out_e_q   <= '0;
      out_p_q   <= '0;
      out_l_q   <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      op_q      <= op_d;
      early_q   <= early_d;
      prompt_q  <= prompt_d;
      late_q    <= late_d;
      out_e_q   <= out_e_d;
      out_p_q   <= out_p_d;
      out_l_q   <= out_l_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign i2q2_valid  = valid_q;
  assign i2q2_early  = out_e_q;
  assign i2q2_prompt = out_p_q;
  assign i2q2_late   = out_l_q;
  assign busy        = (state_q == StSquare);
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_i2q2_engine.sv
// Self-checking bench for i2q2_engine: a scheduled-result model checked every cycle
// plus hand-computed literal expectations at key cycles.
module tb_i2q2_engine;

  localparam int AW = 16;
  localparam int RW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          acc = 1'b0;
  logic [AW-1:0] ie, qe, ip, qp, il, ql;
  logic          valid, busy, ov;
  logic [RW-1:0] oe, op, ol;

  always #5 clk = ~clk;

  i2q2_engine #(.ACC_WIDTH(AW), .I2Q2_WIDTH(RW)) dut (
    .clk                   (clk),
    .global_reset          (rst),
    .accumulation_complete (acc),
    .i_early               (ie),
    .q_early               (qe),
    .i_prompt              (ip),
    .q_prompt              (qp),
    .i_late                (il),
    .q_late                (ql),
    .i2q2_valid            (valid),
    .i2q2_early            (oe),
    .i2q2_prompt           (op),
    .i2q2_late             (ol),
    .busy                  (busy),
    .overrun               (ov)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nvec  = 0;
  int nfail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic logic [63:0] sq(input logic [AW-1:0] v);
    longint s;
    s = longint'($signed(v));
    return 64'(s * s);
  endfunction

  // Model: a strobe schedules its result for 7 cycles later; a newer strobe replaces it.
  bit          armed = 1'b0;
  bit          m_pend = 1'b0;
  int          m_due = 0;
  logic [63:0] m_e, m_p, m_l;
  logic [63:0] x_e, x_p, x_l;
  logic        x_v, x_b, x_o;

  always @(negedge clk) begin
    if (armed) begin
      chk("valid",   {63'd0, valid}, {63'd0, x_v});
      chk("busy",    {63'd0, busy},  {63'd0, x_b});
      chk("overrun", {63'd0, ov},    {63'd0, x_o});
      chk("early",   {32'd0, oe},    x_e);
      chk("prompt",  {32'd0, op},    x_p);
      chk("late",    {32'd0, ol},    x_l);
    end
    if (rst) begin
      m_pend = 1'b0;
      x_v = 1'b0; x_o = 1'b0;
      x_e = '0;   x_p = '0;   x_l = '0;
      armed = 1'b1;
    end else begin
      x_v = 1'b0;
      if (acc) begin
        if (m_pend) x_o = 1'b1;
        m_pend = 1'b1;
        m_due  = cyc + 7;
        m_e    = sq(ie) + sq(qe);
        m_p    = sq(ip) + sq(qp);
        m_l    = sq(il) + sq(ql);
      end else if (m_pend && m_due == cyc + 1) begin
        x_v = 1'b1;
        x_e = m_e; x_p = m_p; x_l = m_l;
        m_pend = 1'b0;
      end
    end
    x_b = m_pend;
  end

  task automatic at(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_in(input int a, input int b, input int c, input int d, input int e,
                        input int f);
    ie = 16'(a); qe = 16'(b); ip = 16'(c); qp = 16'(d); il = 16'(e); ql = 16'(f);
  endtask

  int b;

  initial begin
    set_in(0, 0, 0, 0, 0, 0);
    at(3);
    rst = 1'b0;

    // Basic squares, then back-to-back strobe in the valid cycle with extreme negatives
    b = cyc;
    at(b + 10); set_in(3, -4, 0, 0, -7, 24); acc = 1'b1;
    at(b + 11); acc = 1'b0; set_in(111, -222, 333, -444, 555, -666);
    at(b + 16); chk("basic_busy16", {63'd0, busy}, 64'd1); chk("basic_nv16", {63'd0, valid}, 64'd0);
    at(b + 17);
    chk("basic_valid", {63'd0, valid}, 64'd1);
    chk("basic_early", {32'd0, oe}, 64'd25);
    chk("basic_prompt", {32'd0, op}, 64'd0);
    chk("basic_late", {32'd0, ol}, 64'd625);
    set_in(-32768, -32768, -32768, -32768, -32768, -32768); acc = 1'b1;
    at(b + 18); acc = 1'b0; set_in(1, 2, 3, 4, 5, 6);
    at(b + 23);
    chk("hold_early", {32'd0, oe}, 64'd25);
    chk("hold_late", {32'd0, ol}, 64'd625);
    at(b + 24);
    chk("neg_valid", {63'd0, valid}, 64'd1);
    chk("neg_early", {32'd0, oe}, 64'd2147483648);
    chk("neg_late", {32'd0, ol}, 64'd2147483648);
    chk("b2b_no_overrun", {63'd0, ov}, 64'd0);
    at(b + 30); set_in(32767, 32767, 32767, 32767, 32767, 32767); acc = 1'b1;
    at(b + 31); acc = 1'b0;
    at(b + 37);
    chk("pos_prompt", {32'd0, op}, 64'd2147352578);
    chk("pos_late", {32'd0, ol}, 64'd2147352578);

    // Overrun
    at(b + 45); rst = 1'b1;
    at(b + 46); rst = 1'b0;
    b = cyc;
    at(b + 10); set_in(5, 6, 7, 8, 9, 10); acc = 1'b1;
    at(b + 11); acc = 1'b0;
    at(b + 13); set_in(1, 1, 1, 1, 1, 1); acc = 1'b1;
    at(b + 14); acc = 1'b0; chk("ovr_set", {63'd0, ov}, 64'd1);
    at(b + 17); chk("ovr_no_valid17", {63'd0, valid}, 64'd0);
    at(b + 20);
    chk("ovr_valid20", {63'd0, valid}, 64'd1);
    chk("ovr_early", {32'd0, oe}, 64'd2);
    chk("ovr_prompt", {32'd0, op}, 64'd2);
    at(b + 25); chk("ovr_sticky", {63'd0, ov}, 64'd1);

    // Reset mid-operation
    b = cyc;
    at(b + 10); set_in(100, -200, 300, -400, 500, -600); acc = 1'b1;
    at(b + 11); acc = 1'b0;
    at(b + 12); rst = 1'b1;
    at(b + 13); rst = 1'b0;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_overrun", {63'd0, ov}, 64'd0);
    chk("rst_early", {32'd0, oe}, 64'd0);

    // Reset priority over a coincident strobe
    at(b + 30); rst = 1'b1; acc = 1'b1; set_in(9, 9, 9, 9, 9, 9);
    at(b + 31); rst = 1'b0; acc = 1'b0;
    chk("prio_busy", {63'd0, busy}, 64'd0);
    at(b + 38); chk("prio_no_valid", {63'd0, valid}, 64'd0);
    at(b + 42);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
